// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
//
// Pipeline sequencing controller for the 5-stage MIPS core, sitting at the
// ID/EX boundary next to the forwarding unit. It:
//   - inserts a one-cycle bubble for load-use hazards forwarding cannot cover,
//   - holds the front end for MD_LATENCY cycles per mult/div and pulses start,
//   - flushes IF/ID and bubbles ID/EX on a taken branch resolved in EX.
//
// Optional feature: define HAZARD_STALL_STATS_EN to add two 32-bit stall
// counters (load_stall_cnt, md_stall_cnt). The default build omits them.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   rs_id, rt_id     source register fields of the ID instruction
//   uses_rt_id       ID instruction reads rt
//   md_req_id        ID instruction is mult/div
//   rt_ex            destination (rt) of the EX instruction
//   readmem_ex       EX instruction is a load
//   branch_taken_ex  branch in EX resolved taken
//   pc_write         PC update enable
//   ifid_write       IF/ID register enable
//   idex_bubble      load a NOP into ID/EX
//   ifid_flush       clear IF/ID
//   md_start         one-cycle start pulse to the mult/div unit
//   md_busy          high while waiting on the mult/div unit
//   md_done          one-cycle pulse on the release cycle
//   load_stall_cnt   (stats build) load-use stall cycles, wraps at 2^32
//   md_stall_cnt     (stats build) mult/div stall cycles, wraps at 2^32
//
// Outputs are combinational from the state, the counter and current inputs.
// -----------------------------------------------------------------------------
module hazard_stall_controller #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       uses_rt_id,
    input  logic       md_req_id,
    input  logic [4:0] rt_ex,
    input  logic       readmem_ex,
    input  logic       branch_taken_ex,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       idex_bubble,
    output logic       ifid_flush,
    output logic       md_start,
    output logic       md_busy,
    output logic       md_done
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [31:0] load_stall_cnt,
    output logic [31:0] md_stall_cnt
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             load_hz;
    logic             stall;

    // Load in EX writes a register the ID instruction reads; r0 never hazards.
    assign load_hz = readmem_ex && (rt_ex != 5'd0) &&
                     ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));

    // State and latency counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and control outputs; priority is branch > load_hz > md_req_id.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall       = 1'b0;
        ifid_flush  = 1'b0;
        md_start    = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;
        idex_bubble = 1'b0;

        unique case (state_q)
            RUN: begin
                if (branch_taken_ex) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_hz) begin
                    // Single bubble: the load leaves EX at the next edge.
                    stall = 1'b1;
                end else if (md_req_id) begin
                    stall    = 1'b1;
                    md_start = 1'b1;
                    cnt_d    = CNT_LOAD;
                    state_d  = MD_WAIT;
                end
            end
            MD_WAIT: begin
                md_busy = 1'b1;
                if (branch_taken_ex) begin
                    // Older branch kills the waiting mult/div.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    cnt_d       = '0;
                    state_d     = RUN;
                end else if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    md_done = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        if (stall) begin
            idex_bubble = 1'b1;
        end
        pc_write   = !stall;
        ifid_write = !stall;
    end

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] load_stall_cnt_q;
    logic [31:0] md_stall_cnt_q;
    logic        load_stall;
    logic        md_stall;

    // In RUN a stall with load_hz present is always the load bubble.
    assign load_stall = stall && (state_q == RUN) && load_hz;
    assign md_stall   = stall && !load_stall;

    // Stall statistics, free-running with natural wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_stall_cnt_q <= '0;
            md_stall_cnt_q   <= '0;
        end else begin
            if (load_stall) begin
                load_stall_cnt_q <= load_stall_cnt_q + 32'd1;
            end
            if (md_stall) begin
                md_stall_cnt_q <= md_stall_cnt_q + 32'd1;
            end
        end
    end

    assign load_stall_cnt = load_stall_cnt_q;
    assign md_stall_cnt   = md_stall_cnt_q;
`endif

endmodule
